msg_validity_checker: RTL and testbench
=======================================

# msg_validity_checker

Scans one candidate plaintext from the decryption cores and decides whether every byte is a lowercase ASCII letter or a space. It sits directly downstream of the parallel decryption cores and drives the top-level FSM's DETERMINE state: it starts on a start pulse and reports on a done pulse with msg_valid. It takes a snapshot of the message, so upstream may load the next key as soon as start has been accepted.

## Interface

- MSG_LEN, 32, number of message bytes; must be ≥ 2.
- CHAR_LO, 8'd97, lowest legal letter ('a').
- CHAR_HI, 8'd122, highest legal letter ('z').
- CHAR_SP, 8'd32, the one legal non-letter (space).
- IDX_W, $clog2(MSG_LEN), width of the index.

- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level-sampled; accepted only in IDLE.
- decrypted_data  in  8 × MSG_LEN (unpacked [MSG_LEN-1:0])  candidate plaintext; index 0 is the first byte.
- busy  out  1  high in CHECK and DONE.
- done  out  1  one-cycle pulse; the verdict is valid from this cycle.
- msg_valid  out  1  verdict; held until the next accepted start.
- bad_index  out  IDX_W  index of the first illegal byte; 0 when msg_valid=1.

## Operation

- States: IDLE, CHECK, DONE. All outputs are registered or decoded from the state register. There is no combinational path from start to any output.
- IDLE:
  - If start=1 at the rising edge: copy decrypted_data into the internal snapshot array, set idx←0, msg_valid←0, bad_index←0, and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK: each cycle, evaluate byte snap[idx].
  - A byte is legal iff (CHAR_LO ≤ b ≤ CHAR_HI) or b == CHAR_SP. Compare as 8-bit unsigned.
  - Illegal byte: bad_index←idx, msg_valid←0, go to DONE. This is an early exit; the remaining bytes are not examined.
  - Legal byte with idx == MSG_LEN-1: msg_valid←1, bad_index←0, go to DONE.
  - Legal byte otherwise: idx←idx+1. idx never wraps; it always reaches DONE first.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in CHECK and DONE. It is not queued.
- start held high continuously: a new scan begins in the IDLE cycle after each DONE. Inputs are re-snapshotted each time.
- Changes to decrypted_data after acceptance have no effect on the scan in progress.
- reset=1 at any edge, including mid-scan:
  - State←IDLE, idx←0.
  - Outputs: busy=0, done=0, msg_valid=0, bad_index=0.
  - Reset has priority over start in the same cycle.
  - Snapshot contents are don't-care after reset.

## Timing

- Edge E0 is the edge that samples start=1 in IDLE. At E0, busy rises.
- At edge E(k+1), byte k is evaluated.
- Illegal byte at index k: DONE follows E(k+1).
  - done is high in the cycle between E(k+1) and E(k+2).
  - Latency from start to done is k+2 cycles.
- Fully legal message: done is high between E(MSG_LEN) and E(MSG_LEN+1).
  - Latency is MSG_LEN+1 cycles, i.e. 33 at the default.
- msg_valid and bad_index are updated on the same edge that enters DONE, so they are stable when done is high.
- busy falls at the edge leaving DONE.
- The next start can be accepted at the edge immediately after done.
  - Minimum start-to-start period is k+3 cycles for an illegal message and MSG_LEN+2 for a legal one.
- msg_valid drops to 0 at E0 of the next scan. Consumers must sample the verdict with done, not by level.

## Test plan

- Fully legal message: all 32 bytes 'a' (97), start pulsed 1 cycle.
  - Required: done high exactly 33 cycles after E0, msg_valid=1, bad_index=0, busy low the following cycle.
- Character bounds: bytes alternating 'a', 'z' (122) and ' ' (32); then separately byte 0 = '`' (96).
  - First message: valid, done at cycle 33.
  - Second message: msg_valid=0, bad_index=0, done at cycle 2.
- Early exit: byte 5 = 'A' (65), the rest 'q'. Then, as a separate run, only byte 31 = '{' (123).
  - Byte 5 run: done at cycle 7, msg_valid=0, bad_index=5.
  - Byte 31 run: done at cycle 33, bad_index=31.
- Snapshot and ignore: start a legal scan, then at cycle 3 change decrypted_data[10] to 8'hFF and pulse start again.
  - Required: verdict still valid at cycle 33. The second start has no effect; exactly one done pulse.
- Reset mid-scan: assert reset at cycle 10 of a legal scan for 1 cycle.
  - Required: on the next cycle busy=0, done=0, msg_valid=0, bad_index=0, and no done pulse appears.
  - A fresh start afterwards completes normally in 33 cycles.
- Back-to-back: hold start high across three messages (legal, illegal at index 2, legal).
  - Required: done pulses at cycles 33, 33+1+4 and 38+1+33.
  - Verdicts in order: 1; 0 with bad_index=2; 1.

Source files
------------

// File: rtl/msg_validity_checker_if.sv
// Handshake bundle between the decryption cores / top FSM and the message checker.
// The master side launches a scan; the slave side reports the verdict.
interface msg_validity_checker_if #(
  parameter int MSG_LEN = 32,
  parameter int IDX_W   = $clog2(MSG_LEN)
);
  logic             start;
  logic [7:0]       decrypted_data [MSG_LEN-1:0];
  logic             busy;
  logic             done;
  logic             msg_valid;
  logic [IDX_W-1:0] bad_index;

  modport master (
    output start, decrypted_data,
    input  busy, done, msg_valid, bad_index
  );

  modport slave (
    input  start, decrypted_data,
    output busy, done, msg_valid, bad_index
  );
endinterface

// File: rtl/msg_validity_checker.sv
// Scans a snapshotted candidate plaintext one byte per cycle and reports whether
// every byte is a lowercase letter or a space, exiting early on the first bad byte.
module msg_validity_checker #(
  parameter int         MSG_LEN = 32,
  parameter logic [7:0] CHAR_LO = 8'd97,
  parameter logic [7:0] CHAR_HI = 8'd122,
  parameter logic [7:0] CHAR_SP = 8'd32,
  parameter int         IDX_W   = $clog2(MSG_LEN)
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  msg_validity_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_msg_valid;
  logic [IDX_W-1:0] r_bad_index;
  logic [7:0]       r_snap [MSG_LEN-1:0];

  logic             w_accept;
  logic             w_byte_ok;

  function automatic logic is_legal(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
  endfunction

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_byte_ok = is_legal(r_snap[r_idx]);

  // Snapshot lets upstream move on to the next key once start is accepted.
  always_ff @(posedge CLOCK_50) begin
    if (w_accept) begin
      r_snap <= bus.decrypted_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_msg_valid <= 1'b0;
      r_bad_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_CHECK;
            r_idx       <= '0;
            r_msg_valid <= 1'b0;
            r_bad_index <= '0;
          end
        end
        S_CHECK: begin
          if (!w_byte_ok) begin
            r_bad_index <= r_idx;
            r_msg_valid <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_idx == LAST_IDX) begin
            r_msg_valid <= 1'b1;
            r_bad_index <= '0;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // busy/done are decoded straight from the state register, so start never reaches them combinationally.
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.msg_valid = r_msg_valid;
  assign bus.bad_index = r_bad_index;

endmodule

// File: tb/tb_msg_validity_checker.sv
// Bench for msg_validity_checker: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_msg_validity_checker;

  localparam int MSG_LEN = 32;
  localparam int IDX_W   = $clog2(MSG_LEN);

  logic clk;
  logic rst;

  msg_validity_checker_if #(.MSG_LEN(MSG_LEN)) bus ();

  msg_validity_checker #(.MSG_LEN(MSG_LEN)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a scan is a countdown to a verdict fixed at acceptance.
  function automatic bit legal(input logic [7:0] b);
    return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
  endfunction

  function automatic int first_bad(input logic [7:0] d [MSG_LEN-1:0]);
    for (int i = 0; i < MSG_LEN; i++) if (!legal(d[i])) return i;
    return -1;
  endfunction

  bit m_busy, m_done, m_valid, p_valid;
  int m_bad, p_bad, m_rem;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_valid <= 1'b0;
      m_bad   <= 0;
      m_rem   <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_done  <= 1'b1;
        m_valid <= p_valid;
        m_bad   <= p_bad;
      end
      m_rem <= m_rem - 1;
    end else if (bus.start) begin
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
      m_bad   <= 0;
      p_valid <= (first_bad(bus.decrypted_data) < 0);
      p_bad   <= (first_bad(bus.decrypted_data) < 0) ? 0 : first_bad(bus.decrypted_data);
      m_rem   <= (first_bad(bus.decrypted_data) < 0) ? MSG_LEN : first_bad(bus.decrypted_data) + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy",      int'(bus.busy),      int'(m_busy));
      chk("model_done",      int'(bus.done),      int'(m_done));
      chk("model_msg_valid", int'(bus.msg_valid), int'(m_valid));
      chk("model_bad_index", int'(bus.bad_index), m_bad);
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < MSG_LEN; i++) bus.decrypted_data[i] = v;
  endtask

  function automatic logic [7:0] rnd_byte(input bit clean);
    int r;
    r = $urandom_range(0, 99);
    if (clean || r < 93) return (r % 9 == 0) ? 8'd32 : 8'($urandom_range(97, 122));
    case ($urandom_range(0, 5))
      0: return 8'd96;
      1: return 8'd123;
      2: return 8'd31;
      3: return 8'd33;
      4: return 8'd65;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic new_msg(input bit clean);
    for (int i = 0; i < MSG_LEN; i++) bus.decrypted_data[i] = rnd_byte(clean);
  endtask

  // Called at a negedge with the DUT idle; pulses start and waits for the verdict.
  task automatic run_one(input string nm, input int exp_cyc, input int exp_v, input int exp_bad);
    int c;
    bit seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (!seen && c < 200) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    chk({nm, "_cycle"}, c, exp_cyc);
    chk({nm, "_msg_valid"}, int'(bus.msg_valid), exp_v);
    chk({nm, "_bad_index"}, int'(bus.bad_index), exp_bad);
    @(negedge clk);
    chk({nm, "_busy_after"}, int'(bus.busy), 0);
  endtask

  int done_cyc [3];
  int done_v   [3];
  int done_bad [3];

  initial begin
    int c, pulses, first_c, nd;
    bit v_at_done;

    rst = 1'b1;
    bus.start = 1'b0;
    fill(8'd97);
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_msg_valid", int'(bus.msg_valid), 0);
    chk("reset_bad_index", int'(bus.bad_index), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(8'd97);
    run_one("all_a", 33, 1, 0);

    for (int i = 0; i < MSG_LEN; i++)
      bus.decrypted_data[i] = (i % 3 == 0) ? 8'd97 : (i % 3 == 1) ? 8'd122 : 8'd32;
    run_one("bounds_legal", 33, 1, 0);

    fill(8'd97);
    bus.decrypted_data[0] = 8'd96;
    run_one("backtick_at_0", 2, 0, 0);

    fill(8'd113);
    bus.decrypted_data[5] = 8'd65;
    run_one("upper_at_5", 7, 0, 5);

    fill(8'd97);
    bus.decrypted_data[31] = 8'd123;
    run_one("brace_at_31", 33, 0, 31);

    // Snapshot and ignore: data corruption and a second start mid-scan.
    fill(8'd97);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1; pulses = 0; first_c = 0; v_at_done = 1'b0;
    while (c <= 45) begin
      if (c == 3) begin
        bus.decrypted_data[10] = 8'hFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        pulses++;
        if (first_c == 0) begin
          first_c = c;
          v_at_done = bus.msg_valid;
        end
      end
      @(negedge clk);
      c++;
    end
    chk("snapshot_cycle", first_c, 33);
    chk("snapshot_valid", int'(v_at_done), 1);
    chk("snapshot_pulses", pulses, 1);

    // Reset in the middle of a legal scan.
    fill(8'd97);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (c < 10) begin
      @(negedge clk);
      c++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_msg_valid", int'(bus.msg_valid), 0);
    chk("midrst_bad_index", int'(bus.bad_index), 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    run_one("after_reset", 33, 1, 0);

    // Back-to-back with start held high.
    fill(8'd97);
    bus.start = 1'b1;
    @(negedge clk);
    c = 1; nd = 0;
    fill(8'd98);
    bus.decrypted_data[2] = 8'd48;
    while (nd < 3 && c < 300) begin
      if (bus.done) begin
        done_cyc[nd] = c;
        done_v[nd]   = int'(bus.msg_valid);
        done_bad[nd] = int'(bus.bad_index);
        nd++;
        if (nd == 2) fill(8'd32);
        if (nd == 3) bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    chk("b2b_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_cycle0", done_cyc[0], 33);
      chk("b2b_cycle1", done_cyc[1], 38);
      chk("b2b_cycle2", done_cyc[2], 72);
      chk("b2b_valid0", done_v[0], 1);
      chk("b2b_valid1", done_v[1], 0);
      chk("b2b_bad1", done_bad[1], 2);
      chk("b2b_valid2", done_v[2], 1);
      chk("b2b_bad2", done_bad[2], 0);
    end
    repeat (3) @(negedge clk);

    // Randomized traffic: starts, resets and data churn at arbitrary times.
    new_msg(1'b1);
    for (int i = 0; i < 5000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) new_msg($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 7) == 0)
        bus.decrypted_data[$urandom_range(0, MSG_LEN - 1)] = rnd_byte(1'b0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
